// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage plus IF/ID pipeline register.
// Holds the PC, requests words from instruction memory, registers the
// fetched word with its PC, and handles stalls, redirects and a halt opcode.
module fetch_unit #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       PC_STEP  = 4
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ready,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               id_valid,
   output logic [INSTR_W-1:0] id_instr,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [ADDR_W-1:0]  id_pc_next,
   output logic [1:0]         instruction_type,
   output logic [4:0]         func,
   output logic               halt
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HALTED
   } state_t;

   state_t               state, state_nx;
   logic [ADDR_W-1:0]    pc, pc_nx;
   logic                 id_valid_nx;
   logic [INSTR_W-1:0]   id_instr_nx;
   logic [ADDR_W-1:0]    id_pc_nx;
   logic                 halt_nx;
   logic                 halt_word;

   assign halt_word = (imem_rdata[31:30] == 2'b11);

   // State register, PC and IF/ID register; async reset to the idle image.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         id_valid <= 1'b0;
         id_instr <= '0;
         id_pc    <= '0;
         halt     <= 1'b0;
      end else begin
         state    <= state_nx;
         pc       <= pc_nx;
         id_valid <= id_valid_nx;
         id_instr <= id_instr_nx;
         id_pc    <= id_pc_nx;
         halt     <= halt_nx;
      end
   end

   // Next-state logic: redirect > stall > halt word > fetch > bubble while in REQ.
   always_comb begin
      state_nx    = state;
      pc_nx       = pc;
      id_valid_nx = id_valid;
      id_instr_nx = id_instr;
      id_pc_nx    = id_pc;
      halt_nx     = halt;
      case (state)
         IDLE: begin
            state_nx = REQ;
         end
         REQ: begin
            if (redirect_valid) begin
               pc_nx       = redirect_pc;
               id_valid_nx = 1'b0;
               id_instr_nx = '0;
            end else if (stall) begin
               // hold everything; the same address is presented again
            end else if (imem_ready && halt_word) begin
               state_nx    = HALTED;
               halt_nx     = 1'b1;
               id_valid_nx = 1'b0;
               id_instr_nx = '0;
            end else if (imem_ready) begin
               id_instr_nx = imem_rdata;
               id_pc_nx    = pc;
               id_valid_nx = 1'b1;
               pc_nx       = pc + STEP;
            end else begin
               id_valid_nx = 1'b0;
               id_instr_nx = '0;
            end
         end
         HALTED: begin
            if (redirect_valid) begin
               pc_nx    = redirect_pc;
               halt_nx  = 1'b0;
               state_nx = REQ;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign imem_req         = (state == REQ);
   assign imem_addr        = pc;
   assign id_pc_next       = id_pc + STEP;
   assign instruction_type = id_instr[31:30];
   assign func             = id_instr[29:25];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors push expected IF/ID images into a queue;
// a monitor pops one after each observed edge (or async-reset probe) and compares.
module tb_fetch_unit;

   logic        clk;
   logic        rst, rst_w;
   logic        imem_ready, stall, redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt_en;
   logic        sel;

   // main instance (RESET_PC = 0)
   logic        imem_req;
   logic [31:0] imem_addr, imem_rdata;
   logic        id_valid;
   logic [31:0] id_instr, id_pc, id_pc_next;
   logic [1:0]  instruction_type;
   logic [4:0]  func;
   logic        halt;

   // wrap instance (RESET_PC near top of address space)
   logic        w_imem_req;
   logic [31:0] w_imem_addr, w_imem_rdata;
   logic        w_id_valid;
   logic [31:0] w_id_instr, w_id_pc, w_id_pc_next;
   logic [1:0]  w_instruction_type;
   logic [4:0]  w_func;
   logic        w_halt;

   typedef struct {
      bit          dut;
      bit          v;
      logic [31:0] instr;
      logic [31:0] pc;
      bit          h;
      bit          req;
      logic [31:0] addr;
   } rec_t;

   rec_t q[$];
   event mon_ev;
   int   n_chk  = 0;
   int   n_fail = 0;

   fetch_unit #(
      .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .PC_STEP(4)
   ) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc_next(id_pc_next),
      .instruction_type(instruction_type), .func(func), .halt(halt)
   );

   fetch_unit #(
      .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)
   ) dut_w (
      .clk(clk), .rst(rst_w),
      .imem_req(w_imem_req), .imem_addr(w_imem_addr),
      .imem_ready(imem_ready), .imem_rdata(w_imem_rdata),
      .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(w_id_valid), .id_instr(w_id_instr), .id_pc(w_id_pc), .id_pc_next(w_id_pc_next),
      .instruction_type(w_instruction_type), .func(w_func), .halt(w_halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory contents: each word derived from its address, no accidental halt encodings
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5400_0000;
   endfunction

   assign imem_rdata   = (halt_en && imem_addr == 32'h10) ? 32'hC000_0000 : mem_word(imem_addr);
   assign w_imem_rdata = mem_word(w_imem_addr);

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // monitor: compare the DUT image against the oldest expectation
   initial begin
      rec_t r;
      forever begin
         @(posedge clk or mon_ev);
         #1;
         if (q.size() > 0) begin
            r = q.pop_front();
            if (!r.dut) begin
               chk("id_valid", {31'b0, id_valid}, {31'b0, r.v});
               chk("id_instr", id_instr, r.instr);
               chk("instruction_type", {30'b0, instruction_type}, {30'b0, r.instr[31:30]});
               chk("func", {27'b0, func}, {27'b0, r.instr[29:25]});
               chk("id_pc", id_pc, r.pc);
               chk("id_pc_next", id_pc_next, r.pc + 32'd4);
               chk("halt", {31'b0, halt}, {31'b0, r.h});
               chk("imem_req", {31'b0, imem_req}, {31'b0, r.req});
               chk("imem_addr", imem_addr, r.addr);
            end else begin
               chk("w_id_valid", {31'b0, w_id_valid}, {31'b0, r.v});
               chk("w_id_instr", w_id_instr, r.instr);
               chk("w_id_pc", w_id_pc, r.pc);
               chk("w_id_pc_next", w_id_pc_next, r.pc + 32'd4);
               chk("w_halt", {31'b0, w_halt}, {31'b0, r.h});
               chk("w_imem_req", {31'b0, w_imem_req}, {31'b0, r.req});
               chk("w_imem_addr", w_imem_addr, r.addr);
            end
         end
      end
   end

   // drive one cycle of inputs and queue the image expected after the next edge
   task automatic vec(input bit rdy, input bit st, input bit rv, input logic [31:0] rpc,
                      input bit ev, input logic [31:0] epc, input bit eh,
                      input bit er, input logic [31:0] eaddr);
      rec_t r;
      @(negedge clk);
      imem_ready     = rdy;
      stall          = st;
      redirect_valid = rv;
      redirect_pc    = rpc;
      r.dut   = sel;
      r.v     = ev;
      r.instr = ev ? mem_word(epc) : 32'h0;
      r.pc    = epc;
      r.h     = eh;
      r.req   = er;
      r.addr  = eaddr;
      q.push_back(r);
   endtask

   // mid-cycle reset pulse; reset values must appear with no clock edge
   task automatic rst_chk(input bit which, input logic [31:0] raddr);
      rec_t r;
      @(negedge clk);
      #2;
      if (which) rst_w = 1'b1; else rst = 1'b1;
      r.dut   = which;
      r.v     = 1'b0;
      r.instr = 32'h0;
      r.pc    = 32'h0;
      r.h     = 1'b0;
      r.req   = 1'b0;
      r.addr  = raddr;
      q.push_back(r);
      -> mon_ev;
      #2;
      if (which) rst_w = 1'b0; else rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; rst_w = 1'b1; sel = 1'b0; halt_en = 1'b0;
      imem_ready = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

      // reset image, release; edge 1 is IDLE->REQ
      rst_chk(1'b0, 32'h0);
      // sequential fetch, first valid after edge 2
      vec(1,0,0,0,        1,32'h0,  0,1,32'h4);
      vec(1,0,0,0,        1,32'h4,  0,1,32'h8);
      vec(1,0,0,0,        1,32'h8,  0,1,32'hC);
      // 3-cycle stall at id_pc=8
      vec(1,1,0,0,        1,32'h8,  0,1,32'hC);
      vec(1,1,0,0,        1,32'h8,  0,1,32'hC);
      vec(1,1,0,0,        1,32'h8,  0,1,32'hC);
      vec(1,0,0,0,        1,32'hC,  0,1,32'h10);
      vec(1,0,0,0,        1,32'h10, 0,1,32'h14);
      // redirect beats stall
      vec(1,1,1,32'h100,  0,32'h10, 0,1,32'h100);
      halt_en = 1'b1;
      vec(1,0,0,0,        1,32'h100,0,1,32'h104);
      // halt word at 0x10
      vec(1,0,1,32'h10,   0,32'h100,0,1,32'h10);
      vec(1,0,0,0,        0,32'h100,1,0,32'h10);
      vec(1,1,0,0,        0,32'h100,1,0,32'h10);
      vec(0,0,1,32'h40,   0,32'h100,0,1,32'h40);
      vec(1,0,0,0,        1,32'h40, 0,1,32'h44);
      // redirect beats a same-cycle halt word
      vec(1,0,1,32'h10,   0,32'h40, 0,1,32'h10);
      vec(1,0,1,32'h20,   0,32'h40, 0,1,32'h20);
      // ready toggling 1,0,1
      vec(1,0,0,0,        1,32'h20, 0,1,32'h24);
      vec(0,0,0,0,        0,32'h20, 0,1,32'h24);
      vec(1,0,0,0,        1,32'h24, 0,1,32'h28);
      // stall with ready low holds the valid word
      vec(0,1,0,0,        1,32'h24, 0,1,32'h28);
      // halt again, then async reset mid-halt
      vec(1,0,1,32'h10,   0,32'h24, 0,1,32'h10);
      vec(1,0,0,0,        0,32'h24, 1,0,32'h10);
      imem_ready = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
      rst_chk(1'b0, 32'h0);
      vec(1,0,0,0,        1,32'h0,  0,1,32'h4);

      // wrap-around instance
      sel = 1'b1;
      rst_chk(1'b1, 32'hFFFF_FFF8);
      vec(1,0,0,0,        1,32'hFFFF_FFF8, 0,1,32'hFFFF_FFFC);
      vec(1,0,0,0,        1,32'hFFFF_FFFC, 0,1,32'h0);
      vec(1,0,0,0,        1,32'h0,         0,1,32'h4);
      rst_chk(1'b1, 32'hFFFF_FFF8);

      // drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
      #2;
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
